// File: rtl/qeciphy_rx_boundary_sched.sv
// Receive-side frame scheduler: finds and verifies the FAW position, tracks frame lock,
// and sequences the monitor with FAW/CRC boundary strobes over a 64-word frame.
module qeciphy_rx_boundary_sched #(
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned UNLOCK_COUNT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tvalid_i,
    input  logic       locked_i,
    input  logic       faw_detect_i,
    output logic       enable_o,
    output logic       faw_boundary_o,
    output logic       crc_boundary_o,
    output logic       frame_locked_o,
    output logic       faw_miss_o,
    output logic [7:0] lock_loss_cnt_o
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_TARGET = 4'(UNLOCK_COUNT);

    state_t     state;
    logic [5:0] pos;
    logic [3:0] hits;
    logic [3:0] misses;

    logic word_live;
    logic at_faw;
    logic at_crc;
    logic lock_done;
    logic faw_miss;
    logic last_miss;

    // CRC words close each of the nine 7-word groups that follow the FAW word.
    function automatic logic is_crc_pos(input logic [5:0] p);
        case (p)
            6'd7, 6'd14, 6'd21, 6'd28, 6'd35,
            6'd42, 6'd49, 6'd56, 6'd63: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        word_live = tvalid_i & locked_i & ~rst_i;
        at_faw    = word_live & (pos == 6'd0);
        at_crc    = word_live & is_crc_pos(pos);
        lock_done = (state == VERIFY) & at_faw & faw_detect_i & ((hits + 4'd1) == LOCK_TARGET);
        faw_miss  = (state == LOCKED) & at_faw & ~faw_detect_i;
        last_miss = faw_miss & ((misses + 4'd1) == UNLOCK_TARGET);
    end

    // The lock-completing word already carries enable and the FAW boundary.
    assign enable_o       = ~rst_i & locked_i & ((state == LOCKED) | lock_done);
    assign faw_boundary_o = ((state == LOCKED) & at_faw) | lock_done;
    assign crc_boundary_o = (state == LOCKED) & at_crc;
    assign faw_miss_o     = faw_miss;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: every state register is cleared here; there is no storage array to exempt.
            state           <= SEARCH;
            pos             <= 6'd0;
            hits            <= 4'd0;
            misses          <= 4'd0;
            frame_locked_o  <= 1'b0;
            lock_loss_cnt_o <= 8'd0;
        end else begin
            // NOTE: non-blocking updates, so a later assignment to pos below overrides this advance.
            if (tvalid_i) begin
                pos <= pos + 6'd1;
            end

            if (!locked_i) begin
                if (state == LOCKED) begin
                    lock_loss_cnt_o <= sat_inc(lock_loss_cnt_o);
                end
                state          <= SEARCH;
                hits           <= 4'd0;
                misses         <= 4'd0;
                frame_locked_o <= 1'b0;
            end else if (tvalid_i) begin
                case (state)
                    SEARCH: begin
                        if (faw_detect_i) begin
                            pos   <= 6'd1;
                            hits  <= 4'd1;
                            state <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (at_faw) begin
                            if (!faw_detect_i) begin
                                state <= SEARCH;
                                hits  <= 4'd0;
                            end else if (lock_done) begin
                                state          <= LOCKED;
                                hits           <= hits + 4'd1;
                                misses         <= 4'd0;
                                frame_locked_o <= 1'b1;
                            end else begin
                                hits <= hits + 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (last_miss) begin
                            state           <= SEARCH;
                            hits            <= 4'd0;
                            misses          <= 4'd0;
                            frame_locked_o  <= 1'b0;
                            lock_loss_cnt_o <= sat_inc(lock_loss_cnt_o);
                        end else if (faw_miss) begin
                            misses <= misses + 4'd1;
                        end else if (at_faw) begin
                            misses <= 4'd0;
                        end
                    end
                    default: begin
                        state          <= SEARCH;
                        frame_locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qeciphy_rx_boundary_sched.sv
// Self-checking bench for qeciphy_rx_boundary_sched: vector table, directed frame
// sequences and randomized traffic against a valid-word-index reference model.
module tb_qeciphy_rx_boundary_sched;

    localparam int LC = 3;
    localparam int UC = 4;

    typedef struct packed {
        logic       en;
        logic       fb;
        logic       cb;
        logic       fl;
        logic       miss;
        logic [7:0] cnt;
    } out_t;

    typedef struct {
        logic r;
        logic v;
        logic l;
        logic f;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tvalid;
    logic       lk;
    logic       faw;
    logic       enable;
    logic       faw_boundary;
    logic       crc_boundary;
    logic       frame_locked;
    logic       faw_miss;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int gap_err  = 0;

    // Reference model: position is the count of valid words since the last accepted FAW.
    int   m_mode = 0;   // 0 search, 1 verify, 2 locked
    int   m_vcnt = 0;
    int   m_anchor = 0;
    int   m_hits = 0;
    int   m_misses = 0;
    int   m_loss = 0;
    logic m_locked = 1'b0;

    qeciphy_rx_boundary_sched #(
        .LOCK_COUNT  (LC),
        .UNLOCK_COUNT(UC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tvalid_i       (tvalid),
        .locked_i       (lk),
        .faw_detect_i   (faw),
        .enable_o       (enable),
        .faw_boundary_o (faw_boundary),
        .crc_boundary_o (crc_boundary),
        .frame_locked_o (frame_locked),
        .faw_miss_o     (faw_miss),
        .lock_loss_cnt_o(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int m_pos();
        return ((m_vcnt - m_anchor) % 64 + 64) % 64;
    endfunction

    function automatic out_t model_out(input logic r, input logic v, input logic l, input logic f);
        out_t o;
        int   p;
        logic fawp, crcp, done;
        o = '0;
        o.fl  = m_locked;
        o.cnt = 8'(m_loss);
        if (!r) begin
            p    = m_pos();
            fawp = v && l && (p == 0);
            crcp = v && l && (p != 0) && (p % 7 == 0);
            done = (m_mode == 1) && fawp && f && (m_hits + 1 == LC);
            o.en   = l && ((m_mode == 2) || done);
            o.fb   = ((m_mode == 2) && fawp) || done;
            o.cb   = (m_mode == 2) && crcp;
            o.miss = (m_mode == 2) && fawp && !f;
        end
        return o;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic l, input logic f);
        int p;
        if (r) begin
            m_mode = 0; m_vcnt = 0; m_anchor = 0; m_hits = 0; m_misses = 0; m_loss = 0;
            m_locked = 1'b0;
            return;
        end
        p = m_pos();
        if (!l) begin
            if (m_mode == 2) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            m_mode = 0; m_hits = 0; m_misses = 0;
        end else if (v) begin
            case (m_mode)
                0: if (f) begin m_anchor = m_vcnt; m_hits = 1; m_mode = 1; end
                1: if (p == 0) begin
                       if (f) begin
                           m_hits++;
                           if (m_hits == LC) begin m_mode = 2; m_misses = 0; end
                       end else begin
                           m_mode = 0; m_hits = 0;
                       end
                   end
                default: if (p == 0) begin
                       if (f) m_misses = 0;
                       else begin
                           m_misses++;
                           if (m_misses == UC) begin
                               m_mode = 0; m_misses = 0; m_hits = 0;
                               m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                           end
                       end
                   end
            endcase
        end
        if (v) m_vcnt++;
        m_locked = (m_mode == 2);
    endtask

    task automatic cycle(input logic r, input logic v, input logic l, input logic f, output out_t act);
        out_t exp;
        rst = r; tvalid = v; lk = l; faw = f;
        @(negedge clk);
        act.en   = enable;
        act.fb   = faw_boundary;
        act.cb   = crc_boundary;
        act.fl   = frame_locked;
        act.miss = faw_miss;
        act.cnt  = lock_loss_cnt;
        exp = model_out(r, v, l, f);
        check($sformatf("model@%0t", $time), int'(act), int'(exp));
        if (!v && (act.fb || act.cb || act.miss)) gap_err++;
        model_step(r, v, l, f);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        out_t a;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, a);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, a);
    endtask

    task automatic run_data(input int n, output out_t last);
        last = '0;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, last);
    endtask

    // Leaves the block locked with the next valid word at position 1.
    task automatic acquire(input bit with_reset);
        out_t a;
        if (with_reset) do_reset();
        for (int w = 0; w <= 128; w++) cycle(1'b0, 1'b1, 1'b1, (w % 64) == 0, a);
    endtask

    vec_t tbl[7];

    initial begin
        out_t a;
        logic any;
        int   nvalid, fb_cnt, cb_cnt;
        logic v, f, r;

        tbl[0] = '{r: 1, v: 0, l: 1, f: 0, exp: '0};
        tbl[1] = '{r: 0, v: 1, l: 1, f: 0, exp: '0};
        tbl[2] = '{r: 0, v: 0, l: 1, f: 1, exp: '0};
        tbl[3] = '{r: 0, v: 1, l: 0, f: 1, exp: '0};
        tbl[4] = '{r: 0, v: 1, l: 1, f: 1, exp: '0};
        tbl[5] = '{r: 0, v: 1, l: 1, f: 1, exp: '0};
        tbl[6] = '{r: 1, v: 1, l: 1, f: 1, exp: '0};

        rst = 1'b1; tvalid = 1'b0; lk = 1'b1; faw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_step(1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].f, a);
            check($sformatf("vec%0d", i), int'(a), int'(tbl[i].exp));
        end

        // Idle traffic never locks.
        do_reset();
        any = 1'b0;
        for (int i = 0; i < 500; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, a);
            any |= a.en | a.fb | a.cb | a.miss | a.fl;
        end
        check("idle_quiet", int'(any), 0);

        // Acquisition with FAWs on words 0, 64, 128.
        do_reset();
        for (int w = 0; w <= 192; w++) begin
            cycle(1'b0, 1'b1, 1'b1, (w % 64) == 0, a);
            if (w == 127) check("pre_lock_fl", int'(a.fl), 0);
            if (w == 128) check("lock_word", int'({a.en, a.fb, a.cb}), 6);
            if (w == 129) check("locked_fl", int'(a.fl), 1);
            if (w >= 135 && w <= 191 && ((w - 128) % 7) == 0)
                check($sformatf("crc_w%0d", w), int'({a.fb, a.cb}), 1);
            if (w == 192) check("faw_w192", int'({a.fb, a.cb, a.miss}), 4);
        end

        // False start: miss at 64 abandons verification, FAW at 70 restarts it.
        do_reset();
        for (int w = 0; w <= 199; w++) begin
            cycle(1'b0, 1'b1, 1'b1, (w == 0) || (w == 70) || (w == 134) || (w == 198), a);
            if (w == 134) check("fs_w134", int'({a.en, a.fb}), 0);
            if (w == 198) check("fs_lock_w198", int'({a.en, a.fb}), 3);
            if (w == 199) check("fs_locked", int'(a.fl), 1);
        end

        // Miss tolerance: three misses survive, four drop lock.
        acquire(1'b1);
        for (int k = 0; k < 3; k++) begin
            run_data(63, a);
            cycle(1'b0, 1'b1, 1'b1, 1'b0, a);
            check($sformatf("miss%0d", k), int'({a.en, a.fb, a.miss}), 7);
        end
        run_data(63, a);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, a);
        check("restore_faw", int'({a.fb, a.miss}), 2);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, a);
        check("still_locked", int'({a.fl, a.cnt}), 9'h100);
        run_data(62, a);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, a);
            check($sformatf("drop_miss%0d", k), int'({a.en, a.fb, a.miss}), 7);
            if (k < 3) run_data(63, a);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, a);
        check("unlocked", int'({a.en, a.fb, a.cb, a.miss, a.fl, a.cnt}), 1);

        // Valid gaps: boundaries follow valid-word count only.
        acquire(1'b1);
        nvalid = 1; fb_cnt = 0; cb_cnt = 0; gap_err = 0;
        for (int i = 0; i < 4000 && nvalid <= 192; i++) begin
            v = 1'($urandom % 2);
            f = v && ((nvalid % 64) == 0);
            cycle(1'b0, v, 1'b1, f, a);
            if (a.fb) fb_cnt++;
            if (a.cb) cb_cnt++;
            if (v) nvalid++;
        end
        check("gap_budget", nvalid, 193);
        check("gap_faw_count", fb_cnt, 3);
        check("gap_crc_count", cb_cnt, 27);
        check("gap_invalid_strobe", gap_err, 0);

        // locked_i drop at pos 30.
        acquire(1'b1);
        run_data(29, a);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, a);
        check("lkdrop_outputs", int'({a.en, a.fb, a.cb, a.miss}), 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, a);
        check("lkdrop_state", int'({a.en, a.fl, a.cnt}), 1);

        // Reset at pos 40 while locked clears the loss count too.
        acquire(1'b0);
        run_data(39, a);
        check("prerst_state", int'({a.fl, a.cnt}), 9'h101);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, a);
        check("rst_outputs", int'({a.en, a.fb, a.cb, a.miss}), 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, a);
        check("post_rst", int'(a), 0);

        // Randomized traffic with FAWs mostly at the model's expected position.
        for (int i = 0; i < 6000; i++) begin
            r = ($urandom % 3000) == 0;
            v = ($urandom % 4) != 0;
            f = (m_pos() == 0) ? (($urandom % 8) != 0) : (($urandom % 50) == 0);
            cycle(r, v, ($urandom % 300) != 0, f, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
